// File: rtl/kmeans_iter_engine_if.sv
// Control, load-port and readback signals of the K-means iteration engine.
// The master side (testbench or host) drives run control and points; the slave side is the engine.
interface kmeans_iter_engine_if #(
  parameter int K      = 8,
  parameter int D      = 4,
  parameter int W      = 8,
  parameter int N      = 128,
  parameter int ITER_W = 8
);
  logic                  start;
  logic [ITER_W-1:0]     max_iter;
  logic [W-1:0]          tol;
  logic [K*D*W-1:0]      init_centroid_flat;
  logic                  pt_valid;
  logic                  pt_ready;
  logic [D*W-1:0]        pt_data;
  logic                  busy;
  logic                  done;
  logic                  converged;
  logic [ITER_W-1:0]     iter_count;
  logic [K*D*W-1:0]      centroid_flat;
  logic [$clog2(N)-1:0]  label_idx;
  logic [$clog2(K)-1:0]  label;

  modport master (
    output start, max_iter, tol, init_centroid_flat, pt_valid, pt_data, label_idx,
    input  pt_ready, busy, done, converged, iter_count, centroid_flat, label
  );

  modport slave (
    input  start, max_iter, tol, init_centroid_flat, pt_valid, pt_data, label_idx,
    output pt_ready, busy, done, converged, iter_count, centroid_flat, label
  );
endinterface

// File: rtl/kmeans_iter_engine.sv
// K-means engine: buffers N points, then iterates assign/update passes until the largest
// centroid coordinate movement is within tol or the iteration cap is reached.
module kmeans_iter_engine #(
  parameter int K      = 8,
  parameter int D      = 4,
  parameter int W      = 8,
  parameter int N      = 128,
  parameter int ITER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  kmeans_iter_engine_if.slave bus
);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);
  localparam int DW = 2*W + 2 + $clog2(D);
  localparam int SW = W + NW;
  localparam int CW = NW + 1;
  localparam logic [NW-1:0] LAST_PT = NW'(N-1);
  localparam logic [KW-1:0] LAST_K  = KW'(K-1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ASSIGN = 3'd2,
    UPDATE = 3'd3,
    CHECK  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t                state_r;
  logic signed [W-1:0]   pts_r    [N][D];
  logic [KW-1:0]         labels_r [N];
  logic signed [W-1:0]   cen_r    [K][D];
  logic signed [SW-1:0]  sums_r   [K][D];
  logic [CW-1:0]         cnts_r   [K];
  logic [NW-1:0]         pidx_r;
  logic [KW-1:0]         kidx_r;
  logic [ITER_W-1:0]     max_iter_r;
  logic [ITER_W-1:0]     iter_count_r;
  logic [W-1:0]          tol_r;
  logic [W:0]            maxdelta_r;
  logic                  pt_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  converged_r;

  logic [DW-1:0]         dist_s   [K];
  logic [KW-1:0]         best_s;
  logic [DW-1:0]         best_dist_s;
  logic signed [W-1:0]   newc_s   [D];
  logic [W:0]            upd_max_s;
  logic signed [CW:0]    divisor_s;
  logic [ITER_W-1:0]     iter_next_s;
  logic [K*D*W-1:0]      cflat_s;

  function automatic logic [2*W+1:0] sq_diff(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
    logic signed [W:0]     df;
    logic signed [2*W+1:0] prod;
    df   = {a[W-1], a} - {b[W-1], b};
    prod = (2*W+2)'(df) * (2*W+2)'(df);
    return prod;
  endfunction

  function automatic logic [W:0] abs_diff(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
    logic signed [W:0] df;
    df = {a[W-1], a} - {b[W-1], b};
    return (df[W] == 1'b1) ? -df : df;
  endfunction

  // Exact squared distance of the current point to every centroid; strict < keeps ties on lowest k.
  always_comb begin
    for (int k = 0; k < K; k++) begin
      dist_s[k] = {DW{1'b0}};
      for (int d = 0; d < D; d++) begin
        dist_s[k] = dist_s[k] + DW'(sq_diff(pts_r[pidx_r][d], cen_r[k][d]));
      end
    end
    best_s      = {KW{1'b0}};
    best_dist_s = dist_s[0];
    for (int k = 1; k < K; k++) begin
      best_s      = (dist_s[k] < best_dist_s) ? KW'(k) : best_s;
      best_dist_s = (best_s == KW'(k)) ? dist_s[k] : best_dist_s;
    end
  end

  // Mean of cluster kidx_r (division truncates toward zero) and the running movement maximum.
  always_comb begin
    divisor_s = (cnts_r[kidx_r] == {CW{1'b0}}) ? {{CW{1'b0}}, 1'b1} : {1'b0, cnts_r[kidx_r]};
    upd_max_s = maxdelta_r;
    for (int d = 0; d < D; d++) begin
      newc_s[d] = (cnts_r[kidx_r] == {CW{1'b0}}) ? cen_r[kidx_r][d]
                                                 : W'(sums_r[kidx_r][d] / divisor_s);
      upd_max_s = (abs_diff(newc_s[d], cen_r[kidx_r][d]) > upd_max_s)
                ? abs_diff(newc_s[d], cen_r[kidx_r][d]) : upd_max_s;
    end
  end

  assign iter_next_s = iter_count_r + ITER_W'(1'b1);

  // Flatten centroid registers onto the readback bus.
  always_comb begin
    cflat_s = {(K*D*W){1'b0}};
    for (int k = 0; k < K; k++) begin
      for (int d = 0; d < D; d++) begin
        cflat_s[(k*D+d)*W +: W] = cen_r[k][d];
      end
    end
  end

  // Run-control FSM with point buffer, accumulators and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pidx_r       <= {NW{1'b0}};
      kidx_r       <= {KW{1'b0}};
      max_iter_r   <= {ITER_W{1'b0}};
      iter_count_r <= {ITER_W{1'b0}};
      tol_r        <= {W{1'b0}};
      maxdelta_r   <= {(W+1){1'b0}};
      pt_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      converged_r  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        labels_r[i] <= {KW{1'b0}};
        for (int d = 0; d < D; d++) pts_r[i][d] <= {W{1'b0}};
      end
      for (int k = 0; k < K; k++) begin
        cnts_r[k] <= {CW{1'b0}};
        for (int d = 0; d < D; d++) begin
          cen_r[k][d]  <= {W{1'b0}};
          sums_r[k][d] <= {SW{1'b0}};
        end
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            max_iter_r   <= (bus.max_iter == {ITER_W{1'b0}}) ? ITER_W'(1'b1) : bus.max_iter;
            tol_r        <= bus.tol;
            iter_count_r <= {ITER_W{1'b0}};
            converged_r  <= 1'b0;
            maxdelta_r   <= {(W+1){1'b0}};
            pidx_r       <= {NW{1'b0}};
            pt_ready_r   <= 1'b1;
            busy_r       <= 1'b1;
            for (int k = 0; k < K; k++) begin
              cnts_r[k] <= {CW{1'b0}};
              for (int d = 0; d < D; d++) begin
                cen_r[k][d]  <= bus.init_centroid_flat[(k*D+d)*W +: W];
                sums_r[k][d] <= {SW{1'b0}};
              end
            end
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (bus.pt_valid) begin
            for (int d = 0; d < D; d++) pts_r[pidx_r][d] <= bus.pt_data[d*W +: W];
            if (pidx_r == LAST_PT) begin
              pidx_r     <= {NW{1'b0}};
              pt_ready_r <= 1'b0;
              state_r    <= ASSIGN;
            end else begin
              pidx_r <= pidx_r + NW'(1'b1);
            end
          end
        end
        ASSIGN: begin
          labels_r[pidx_r] <= best_s;
          cnts_r[best_s]   <= cnts_r[best_s] + CW'(1'b1);
          for (int d = 0; d < D; d++) begin
            sums_r[best_s][d] <= sums_r[best_s][d] + {{NW{pts_r[pidx_r][d][W-1]}}, pts_r[pidx_r][d]};
          end
          if (pidx_r == LAST_PT) begin
            pidx_r  <= {NW{1'b0}};
            kidx_r  <= {KW{1'b0}};
            state_r <= UPDATE;
          end else begin
            pidx_r <= pidx_r + NW'(1'b1);
          end
        end
        UPDATE: begin
          for (int d = 0; d < D; d++) cen_r[kidx_r][d] <= newc_s[d];
          maxdelta_r <= upd_max_s;
          if (kidx_r == LAST_K) begin
            state_r <= CHECK;
          end else begin
            kidx_r <= kidx_r + KW'(1'b1);
          end
        end
        CHECK: begin
          iter_count_r <= iter_next_s;
          if (maxdelta_r <= {1'b0, tol_r}) begin
            converged_r <= 1'b1;
            done_r      <= 1'b1;
            state_r     <= FIN;
          end else if (iter_next_s == max_iter_r) begin
            converged_r <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= FIN;
          end else begin
            maxdelta_r <= {(W+1){1'b0}};
            for (int k = 0; k < K; k++) begin
              cnts_r[k] <= {CW{1'b0}};
              for (int d = 0; d < D; d++) sums_r[k][d] <= {SW{1'b0}};
            end
            state_r <= ASSIGN;
          end
        end
        FIN: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r     <= 1'b0;
          pt_ready_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.pt_ready      = pt_ready_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.converged     = converged_r;
  assign bus.iter_count    = iter_count_r;
  assign bus.centroid_flat = cflat_s;
  assign bus.label         = labels_r[bus.label_idx];
endmodule
